// File: rtl/count_enable_gen.sv
// Programmable enable-pulse generator: divides clk by div+1 and emits one-cycle
// en pulses in continuous, single-shot or fixed-length burst mode.
module count_enable_gen #(
    parameter int PRESC_W = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] div,
    input  logic [BURST_W-1:0] burst_len,
    output logic               en,
    output logic               busy,
    output logic               done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [1:0] MODE_CONT  = 2'd0;
    localparam logic [1:0] MODE_BURST = 2'd2;

    logic [0:0]         state;
    logic [1:0]         mode_q;
    logic [PRESC_W-1:0] div_q;
    logic [BURST_W-1:0] blen_q;
    logic [PRESC_W-1:0] presc;
    logic [BURST_W-1:0] pcnt;
    logic               last_pulse;

    // Whether the pulse firing at this edge ends the run; reserved mode acts as single.
    always_comb begin
        last_pulse = 1'b1;
        if (mode_q == MODE_CONT)
            last_pulse = 1'b0;
        else if (mode_q == MODE_BURST)
            last_pulse = (pcnt == blen_q);
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order in this block.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            mode_q <= '0;
            div_q  <= '0;
            blen_q <= '0;
            presc  <= '0;
            pcnt   <= '0;
            en     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            en   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy still high here means this is the cycle of the final en;
                    // drop busy and ignore start until the next edge.
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start && !stop) begin
                        mode_q <= mode;
                        div_q  <= div;
                        blen_q <= burst_len;
                        presc  <= '0;
                        pcnt   <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (presc == div_q) begin
                        en    <= 1'b1;
                        presc <= '0;
                        pcnt  <= pcnt + 1'b1;
                        if (last_pulse) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/count_enable_gen.md
# count_enable_gen

Programmable enable-pulse generator that drives the `en` input of the parameterised up/down counter stage directly downstream. It divides `clk` by a programmable ratio and emits one-cycle `en` pulses in one of three modes: continuous, single-shot, or fixed-length burst. A start/stop/busy/done control interface lets a sequencer advance the counter at a controlled rate or by an exact number of steps.

## Interface
- PRESC_W, 8: width of the divide-ratio input and the internal prescaler.
- BURST_W, 4: width of the burst-length input and the internal pulse counter.

- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  start request; sampled only while idle.
- stop  in  1  abort request; sampled only while running.
- mode  in  2  0 = continuous, 1 = single, 2 = burst, 3 = reserved (behaves as single).
- div  in  PRESC_W  pulse period minus one (period = div+1 cycles).
- burst_len  in  BURST_W  burst pulse count minus one (pulses = burst_len+1).
- en  out  1  one-cycle enable pulse to the counter.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse marking normal completion of a single or burst run.

## Operation
- Two states: IDLE and RUN. All outputs are registered.
- Reset (rstn low at an edge): state IDLE, prescaler 0, pulse counter 0, en/busy/done = 0. Reset overrides every other input, including mid-run; no done is generated.
- IDLE:
  - start high at an edge latches mode, div and burst_len; clears the prescaler and pulse counter; enters RUN; sets busy.
  - If start and stop are high at the same edge, stop wins and the block stays IDLE.
- RUN, at each edge:
  - If the prescaler equals latched div, assert en for the next cycle, clear the prescaler and increment the pulse counter. Otherwise increment the prescaler and drive en 0.
  - Live mode, div and burst_len inputs are ignored until the next start.
- Termination:
  - Single: after the first pulse.
  - Burst: after pulse number burst_len+1 (pulse counter equals latched burst_len when the pulse fires).
  - Continuous: never terminates; only stop or reset ends it.
  - On termination, done is asserted in the same cycle as the final en, and the state returns to IDLE.
- stop high at an edge in RUN returns to IDLE and clears busy. Any en that would have fired at that edge is suppressed. done stays 0.
- start while busy is ignored and not queued.
- Pulse counter arithmetic is unsigned BURST_W-bit. Maximum burst length is 2^BURST_W pulses. Prescaler wrap is governed only by the compare against div; there is no natural overflow.

## Timing
- start sampled at edge 0: busy = 1 from cycle 0.
- First en occurs in cycle div+1. Subsequent en pulses occur every div+1 cycles.
- div = 0: en high in every cycle from cycle 1.
- en, and done when present, are exactly one cycle wide.
- busy stays high through the cycle of the final en inclusive and is 0 from the following cycle. A new start can be accepted at the first edge where busy is 0.
- stop sampled at edge s: busy = 0 and en = 0 from cycle s.
- Latency from start to last en in burst mode: (burst_len+1)·(div+1) cycles.

## Test plan
- Reset: hold rstn low 3 cycles with start = 1 -> en = busy = done = 0 throughout. The first start after release is accepted.
- Continuous, div = 2: start -> en in cycles 3, 6, 9, 12… and done never asserts. stop at edge 10 -> en stays 0 and busy = 0 from cycle 10.
- Single, div = 0: start -> exactly one en in cycle 1, with done also high in cycle 1 and busy = 0 in cycle 2. A second start issued in cycle 1 is ignored.
- Burst, div = 1, burst_len = 3: start -> en in cycles 2, 4, 6, 8 (exactly 4 pulses), with done only in cycle 8. Changing div to 5 mid-run has no effect.
- Burst, burst_len = 15, div = 0: exactly 16 consecutive en pulses then done, checking the pulse-counter wrap. Feeding en into a 4-bit up counter returns it to 0.
- Corner cases:
  - stop at the same edge where en would fire -> no en and no done.
  - start and stop together while idle -> stays idle.
  - rstn low mid-burst -> outputs 0 next cycle and no done.
